spi_mem_ctrl: RTL and testbench
===============================

# spi_mem_ctrl

Serial memory controller between the control FSM and two external SPI devices: program flash and data RAM. It accepts the registered `mem_ctrl_op` / `addr_sel` request from `ctrl`, runs one SPI read or write transaction on the selected chip, and returns `mem_op_done` with read data for the data mux. Only one transaction is in flight at a time.

## Interface

Parameters:
- `ADDR_WIDTH`, 16: address bits sent per transaction; a multiple of 8.
- `DATA_BUS_WIDTH`, 8: data byte width; fixed at 8.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `mem_ctrl_op`  in  2  request code, held until done:
  - 0 = MEM_NOP
  - 1 = MEM_READ
  - 2 = MEM_WRITE
  - 3 = treated as MEM_NOP
- `addr_sel`  in  1  chip select source: 0 = PC (flash), 1 = MAR (RAM)
- `addr`  in  ADDR_WIDTH  byte address from the address register selected by `addr_sel`
- `data_in`  in  8  write data from the ALU path
- `data_out`  out  8  last byte read
- `mem_op_done`  out  1  one-cycle completion pulse
- `spi_sclk`  out  1  SPI clock, mode 0
- `spi_mosi`  out  1  serial data out
- `spi_miso`  in  1  serial data in
- `spi_cs_flash_n`  out  1  flash chip select, active-low
- `spi_cs_ram_n`  out  1  RAM chip select, active-low

## Operation

States:
- IDLE
  - Sample `mem_ctrl_op` every cycle.
  - On READ or WRITE: capture `addr`, `addr_sel`, `data_in` and the op. Load the frame shift register. Go to SHIFT.
  - WRITE with `addr_sel`=PC (flash) starts no SPI traffic: go directly to DONE.
- SHIFT
  - The selected CS is low and the other stays high.
  - Frame is N = 16 + ADDR_WIDTH bits, MSB first: command byte (0x03 read, 0x02 write), then address, then data byte (`data_in` for write, don't-care 0x00 for read).
  - Each bit takes two clocks: a low phase (`spi_sclk`=0, `spi_mosi` presents the bit), then a high phase (`spi_sclk`=1).
  - `spi_miso` is sampled on the clock edge that raises `spi_sclk`.
  - After the high phase of bit N-1, go to DONE.
- DONE
  - `mem_op_done`=1 for exactly this cycle.
  - Both CS high, `spi_sclk`=0.
  - For a read, `data_out` takes the last 8 sampled MISO bits, registered so the value is visible in this cycle.
  - Next state is always IDLE. Requests are not sampled in DONE.

Other rules:
- A bit counter of width clog2(2N) counts phases. `mem_ctrl_op` changing during SHIFT is ignored.
- `data_out` holds its value until the next completed read. Writes and flash-write drops leave it unchanged.

## Timing

- Reset values (reset=0, asynchronous):
  - state IDLE, `mem_op_done`=0, `data_out`=0x00
  - `spi_sclk`=0, `spi_mosi`=0
  - both CS_n=1
  - counter and shift register cleared
- Reset asserted mid-SHIFT: CS deasserts immediately (asynchronously), no done pulse. After release the block is in IDLE.
- All outputs are registered.
- Latency, for a request first seen in IDLE at cycle t:
  - CS low and first MOSI bit at t+1.
  - `mem_op_done` at t+2N+1. For ADDR_WIDTH=16: N=32, done at t+65.
  - Flash write: done at t+1, no CS activity.
- Handshake: `ctrl` holds the op until it samples done; its registered op returns to NOP no later than done+1. The IDLE cycle after DONE therefore sees NOP, so one request produces exactly one transaction.
- Back-to-back: a new request at done+1 or later starts normally. There are at least 2 idle cycles with CS high between frames.
- `spi_sclk` idles low. MOSI changes only while `spi_sclk` is low.

## Test plan

- Reset mid-frame: assert reset at cycle 20 of a RAM read -> CS_n=1 and sclk=0 at once; after release, no done pulse and the block is in IDLE.
- Flash read, addr=0x1234, flash model returns 0xA5 -> only `spi_cs_flash_n` goes low. MOSI carries 0x03,0x12,0x34,0x00 with 32 rising sclk edges. Done one cycle at t+65 with `data_out`=0xA5.
- RAM write, addr_sel=MAR, addr=0x00FF, data_in=0x3C -> only `spi_cs_ram_n` goes low. MOSI carries 0x02,0x00,0xFF,0x3C. Done at t+65. `data_out` unchanged.
- Flash write request -> done at t+1, both CS_n stay 1, sclk stays 0.
- Op held at READ through done, then NOP; immediately followed by a second READ at addr 0x0001 -> exactly two frames, separated by CS-high gap ≥2 cycles. Second `data_out` matches model byte.
- op=3 or `mem_ctrl_op` toggled during SHIFT -> no transaction started for 3; the in-flight frame completes unchanged.

Source files
------------

// File: rtl/spi_mem_ctrl_if.sv
// Request/response and SPI pin bundle for spi_mem_ctrl.
// slave = controller side, master = control FSM plus external devices.
`timescale 1ns/1ps
interface spi_mem_ctrl_if #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_BUS_WIDTH = 8
);
    logic [1:0]                mem_ctrl_op;
    logic                      addr_sel;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_BUS_WIDTH-1:0] data_in;
    logic [DATA_BUS_WIDTH-1:0] data_out;
    logic                      mem_op_done;
    logic                      spi_sclk;
    logic                      spi_mosi;
    logic                      spi_miso;
    logic                      spi_cs_flash_n;
    logic                      spi_cs_ram_n;

    modport slave (
        input  mem_ctrl_op, addr_sel, addr, data_in, spi_miso,
        output data_out, mem_op_done, spi_sclk, spi_mosi, spi_cs_flash_n, spi_cs_ram_n
    );

    modport master (
        output mem_ctrl_op, addr_sel, addr, data_in, spi_miso,
        input  data_out, mem_op_done, spi_sclk, spi_mosi, spi_cs_flash_n, spi_cs_ram_n
    );
endinterface

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: one read/write frame on flash (PC) or RAM (MAR)
// per request, with a single-cycle done pulse.
`timescale 1ns/1ps
module spi_mem_ctrl #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_BUS_WIDTH = 8
) (
    input logic          clock,
    input logic          reset,
    spi_mem_ctrl_if.slave bus
);
    localparam int N  = 8 + ADDR_WIDTH + DATA_BUS_WIDTH;
    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2} op_t;

    state_t                    state, state_nx;
    logic [CW-1:0]             cnt, cnt_nx;
    logic [N-1:0]              frame, frame_nx;
    logic [DATA_BUS_WIDTH-1:0] rx, rx_nx;
    logic [DATA_BUS_WIDTH-1:0] dout, dout_nx;
    logic                      is_read, is_read_nx;
    logic                      sel, sel_nx;
    logic                      sclk, sclk_nx;
    logic                      cs_flash_n, cs_flash_n_nx;
    logic                      cs_ram_n, cs_ram_n_nx;
    logic                      done, done_nx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            frame      <= '0;
            rx         <= '0;
            dout       <= '0;
            is_read    <= 1'b0;
            sel        <= 1'b0;
            sclk       <= 1'b0;
            cs_flash_n <= 1'b1;
            cs_ram_n   <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            frame      <= frame_nx;
            rx         <= rx_nx;
            dout       <= dout_nx;
            is_read    <= is_read_nx;
            sel        <= sel_nx;
            sclk       <= sclk_nx;
            cs_flash_n <= cs_flash_n_nx;
            cs_ram_n   <= cs_ram_n_nx;
            done       <= done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        frame_nx      = frame;
        rx_nx         = rx;
        dout_nx       = dout;
        is_read_nx    = is_read;
        sel_nx        = sel;
        sclk_nx       = 1'b0;
        cs_flash_n_nx = 1'b1;
        cs_ram_n_nx   = 1'b1;
        done_nx       = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.mem_ctrl_op == MEM_READ || bus.mem_ctrl_op == MEM_WRITE) begin
                    is_read_nx = (bus.mem_ctrl_op == MEM_READ);
                    sel_nx     = bus.addr_sel;
                    if (bus.mem_ctrl_op == MEM_WRITE && !bus.addr_sel) begin
                        // Flash is read-only: acknowledge without touching the bus.
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx      = SHIFT;
                        cnt_nx        = '0;
                        frame_nx      = {(bus.mem_ctrl_op == MEM_READ) ? 8'h03 : 8'h02,
                                         bus.addr,
                                         (bus.mem_ctrl_op == MEM_READ) ? '0 : bus.data_in};
                        cs_flash_n_nx = bus.addr_sel;
                        cs_ram_n_nx   = !bus.addr_sel;
                    end
                end
            end
            SHIFT: begin
                cs_flash_n_nx = sel;
                cs_ram_n_nx   = !sel;
                cnt_nx        = cnt + CW'(1);
                if (!cnt[0]) begin
                    // Edge that raises sclk is also the MISO sample point.
                    sclk_nx = 1'b1;
                    rx_nx   = {rx[DATA_BUS_WIDTH-2:0], bus.spi_miso};
                end else if (cnt == CW'(2 * N - 1)) begin
                    state_nx      = DONE;
                    cnt_nx        = '0;
                    frame_nx      = '0;
                    cs_flash_n_nx = 1'b1;
                    cs_ram_n_nx   = 1'b1;
                    done_nx       = 1'b1;
                    if (is_read)
                        dout_nx = rx;
                end else begin
                    frame_nx = {frame[N-2:0], 1'b0};
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // MOSI is the frame register MSB, so it only moves on low-phase entries.
    assign bus.spi_mosi       = frame[N-1];
    assign bus.spi_sclk       = sclk;
    assign bus.spi_cs_flash_n = cs_flash_n;
    assign bus.spi_cs_ram_n   = cs_ram_n;
    assign bus.mem_op_done    = done;
    assign bus.data_out       = dout;
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: SPI flash/RAM device models, directed table, random
// requests against a byte-level memory model, and a pin-level protocol monitor.
`timescale 1ns/1ps
module tb_spi_mem_ctrl;
    localparam int AW = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    spi_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_BUS_WIDTH(8)) bus ();
    spi_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_BUS_WIDTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Device memories (behind SPI) and the reference model's own copies.
    logic [7:0] flash_mem [65536];
    logic [7:0] ram_mem   [65536];
    logic [7:0] ref_flash [65536];
    logic [7:0] ref_ram   [65536];

    logic cs_idle;
    assign cs_idle = bus.spi_cs_flash_n & bus.spi_cs_ram_n;

    int          bitcnt     = 0;
    int          sdev       = 0;
    logic [31:0] sh         = '0;
    logic [7:0]  rcmd       = '0;
    logic [15:0] raddr      = '0;
    int          frame_cnt  = 0;
    logic [31:0] last_frame = '0;
    int          last_edges = 0;
    int          last_dev   = 0;

    // SPI slave: capture MOSI on rising sclk, close the frame when CS rises.
    always @(posedge bus.spi_sclk or posedge cs_idle) begin
        if (cs_idle) begin
            if (bitcnt != 0) begin
                frame_cnt++;
                last_frame = sh;
                last_edges = bitcnt;
                last_dev   = sdev;
            end
            bitcnt = 0;
        end else begin
            if (bitcnt == 0) sdev = bus.spi_cs_flash_n ? 2 : 1;
            sh = {sh[30:0], bus.spi_mosi};
            bitcnt++;
            if (bitcnt == 24) begin
                rcmd  = sh[23:16];
                raddr = sh[15:0];
            end
            if (bitcnt == 32 && rcmd == 8'h02 && sdev == 2) ram_mem[raddr] = sh[7:0];
        end
    end

    // Slave drives the next bit after each falling sclk; noise outside the data byte.
    always @(negedge bus.spi_sclk or negedge cs_idle) begin
        if (!cs_idle && bitcnt >= 24 && bitcnt < 32 && rcmd == 8'h03) begin
            if (sdev == 1) bus.spi_miso = flash_mem[raddr][31-bitcnt];
            else           bus.spi_miso = ram_mem[raddr][31-bitcnt];
        end else begin
            bus.spi_miso = 1'($urandom);
        end
    end

    logic prev_mosi = 1'b0;
    logic prev_idle = 1'b1;
    int   gap       = 100;
    int   viol      = 0;

    always @(negedge clock) begin
        if (reset) begin
            if (!bus.spi_cs_flash_n && !bus.spi_cs_ram_n) viol++;
            if (bus.spi_sclk && bus.spi_mosi !== prev_mosi) viol++;
            if (bus.spi_sclk && cs_idle) viol++;
        end
        if (cs_idle) gap++;
        else begin
            if (reset && prev_idle && gap < 2) viol++;
            gap = 0;
        end
        prev_mosi = bus.spi_mosi;
        prev_idle = cs_idle;
    end

    task automatic do_txn(input logic [1:0] op, input logic sel, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] exp_dout, input int exp_lat,
                          input int exp_dev, input logic [31:0] exp_frame, input bit wiggle,
                          input string tag);
        int cyc;
        int f0;
        bit seen;
        f0   = frame_cnt;
        cyc  = 0;
        seen = 0;
        bus.mem_ctrl_op = op;
        bus.addr_sel    = sel;
        bus.addr        = a;
        bus.data_in     = d;
        if (exp_lat == 0) begin
            repeat (12) begin
                @(posedge clock); #1;
                if (bus.mem_op_done) seen = 1;
            end
            chk({tag, " no_done"}, 64'(seen), 64'(0));
            bus.mem_ctrl_op = 2'd0;
        end else begin
            while (!seen && cyc < 150) begin
                @(posedge clock); #1;
                cyc++;
                if (bus.mem_op_done) seen = 1;
                else if (wiggle) bus.mem_ctrl_op = (cyc < 60) ? 2'($urandom) : op;
            end
            if (!seen) cyc = -1;
            chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
            chk({tag, " data_out"}, 64'(bus.data_out), 64'(exp_dout));
            bus.mem_ctrl_op = 2'd0;
            @(posedge clock); #1;
            chk({tag, " done_width"}, 64'(bus.mem_op_done), 64'(0));
        end
        chk({tag, " data_out_hold"}, 64'(bus.data_out), 64'(exp_dout));
        chk({tag, " frames"}, 64'(frame_cnt - f0), 64'(exp_dev != 0));
        if (exp_dev != 0) begin
            chk({tag, " frame"}, 64'(last_frame), 64'(exp_frame));
            chk({tag, " sclk_edges"}, 64'(last_edges), 64'(32));
            chk({tag, " chip"}, 64'(last_dev), 64'(exp_dev));
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        sel;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  dout;
        int          lat;
        int          dev;
        logic [31:0] frame;
        bit          wiggle;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [1:0]  op;
        logic        sel;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  model_dout;
        int          lat;
        int          dev;
        logic [31:0] fr;
        bit          seen;

        for (int i = 0; i < 65536; i++) begin
            flash_mem[i] = 8'((i * 7 + (i >> 8) + 90) & 255);
            ram_mem[i]   = 8'((i * 13 + (i >> 8) + 33) & 255);
        end
        flash_mem[16'h1234] = 8'hA5;
        flash_mem[16'h0001] = 8'hC3;
        ram_mem[16'hFFFF]   = 8'h81;
        for (int i = 0; i < 65536; i++) begin
            ref_flash[i] = flash_mem[i];
            ref_ram[i]   = ram_mem[i];
        end

        tbl[0] = '{2'd1, 1'b0, 16'h1234, 8'h00, 8'hA5, 65, 1, 32'h03123400, 1'b0};
        tbl[1] = '{2'd1, 1'b0, 16'h0001, 8'h00, 8'hC3, 65, 1, 32'h03000100, 1'b0};
        tbl[2] = '{2'd2, 1'b1, 16'h00FF, 8'h3C, 8'hC3, 65, 2, 32'h0200FF3C, 1'b0};
        tbl[3] = '{2'd2, 1'b0, 16'h0010, 8'h77, 8'hC3, 1,  0, 32'h0,        1'b0};
        tbl[4] = '{2'd1, 1'b1, 16'h00FF, 8'h00, 8'h3C, 65, 2, 32'h0300FF00, 1'b1};
        tbl[5] = '{2'd3, 1'b1, 16'h0055, 8'h99, 8'h3C, 0,  0, 32'h0,        1'b0};
        tbl[6] = '{2'd1, 1'b1, 16'hFFFF, 8'h00, 8'h81, 65, 2, 32'h03FFFF00, 1'b0};
        tbl[7] = '{2'd2, 1'b1, 16'h0000, 8'hFF, 8'h81, 65, 2, 32'h020000FF, 1'b0};
        tbl[8] = '{2'd1, 1'b1, 16'h0000, 8'h00, 8'hFF, 65, 2, 32'h03000000, 1'b0};
        tbl[9] = '{2'd0, 1'b0, 16'h1234, 8'h00, 8'hFF, 0,  0, 32'h0,        1'b0};

        bus.mem_ctrl_op = 2'd0;
        bus.addr_sel    = 1'b0;
        bus.addr        = '0;
        bus.data_in     = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst done", 64'(bus.mem_op_done), 64'(0));
        chk("rst data_out", 64'(bus.data_out), 64'(0));
        chk("rst sclk", 64'(bus.spi_sclk), 64'(0));
        chk("rst mosi", 64'(bus.spi_mosi), 64'(0));
        chk("rst cs_flash_n", 64'(bus.spi_cs_flash_n), 64'(1));
        chk("rst cs_ram_n", 64'(bus.spi_cs_ram_n), 64'(1));
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++) begin
            do_txn(tbl[i].op, tbl[i].sel, tbl[i].addr, tbl[i].wdata, tbl[i].dout,
                   tbl[i].lat, tbl[i].dev, tbl[i].frame, tbl[i].wiggle, $sformatf("vec%0d", i));
            if (tbl[i].op == 2'd2 && tbl[i].sel) ref_ram[tbl[i].addr] = tbl[i].wdata;
        end

        // Asynchronous reset in the middle of a RAM read.
        bus.mem_ctrl_op = 2'd1;
        bus.addr_sel    = 1'b1;
        bus.addr        = 16'h0042;
        repeat (20) begin @(posedge clock); #1; end
        chk("midrst cs_ram_before", 64'(bus.spi_cs_ram_n), 64'(0));
        #2 reset = 1'b0;
        #1;
        chk("midrst cs_ram_n", 64'(bus.spi_cs_ram_n), 64'(1));
        chk("midrst cs_flash_n", 64'(bus.spi_cs_flash_n), 64'(1));
        chk("midrst sclk", 64'(bus.spi_sclk), 64'(0));
        chk("midrst data_out", 64'(bus.data_out), 64'(0));
        bus.mem_ctrl_op = 2'd0;
        @(posedge clock); #1;
        reset = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clock); #1;
            if (bus.mem_op_done || !cs_idle) seen = 1;
        end
        chk("midrst quiet", 64'(seen), 64'(0));
        model_dout = 8'h00;
        do_txn(2'd2, 1'b0, 16'h0042, 8'h11, model_dout, 1, 0, 32'h0, 1'b0, "midrst idle");

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            sel = 1'($urandom);
            a   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            d   = 8'($urandom);
            lat = 0;
            dev = 0;
            fr  = '0;
            if (op == 2'd1) begin
                lat        = 65;
                dev        = sel ? 2 : 1;
                model_dout = sel ? ref_ram[a] : ref_flash[a];
                fr         = {8'h03, a, 8'h00};
            end else if (op == 2'd2) begin
                if (sel) begin
                    lat        = 65;
                    dev        = 2;
                    fr         = {8'h02, a, d};
                    ref_ram[a] = d;
                end else begin
                    lat = 1;
                end
            end
            do_txn(op, sel, a, d, model_dout, lat, dev, fr,
                   (lat == 65) && ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end

        chk("protocol violations", 64'(viol), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
